// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared cell timing constants and FSM state type for the Manchester link
package manchester_pkg;

  localparam int CELL_CLKS  = 16;
  localparam int HALF_CELL  = 8;
  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} mtx_state_t;

endpackage

// File: rtl/manchester_encoder.sv
// rtl/manchester_encoder.sv - double-buffered Manchester serial transmitter
// One start cell plus 8 MSB-first data cells per frame, then a forced low gap.
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int GAP_CELLS = 2
) (
  input  logic       clk16x,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wrn,
  output logic       tbre,
  output logic       tsre,
  output logic       mdo
);

  localparam logic [3:0] PHASE_LAST = 4'(CELL_CLKS - 1);
  localparam logic [3:0] PHASE_HALF = 4'(HALF_CELL);
  localparam logic [3:0] BIT_LAST   = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CELLS - 1);

  mtx_state_t r_state, w_next_state;
  logic [3:0] r_phase, r_bitcnt, r_gapcnt;
  logic [7:0] r_thr, r_rsr;
  logic       r_full, r_mdo;
  logic       w_cell_end, w_second_half, w_load, w_write, w_mdo_next;

  assign w_cell_end    = (r_phase == PHASE_LAST);
  assign w_second_half = (r_phase >= PHASE_HALF);
  // r_full is the pre-edge view, so a write racing a transfer is dropped
  assign w_write       = ~wrn & ~r_full;

  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_mdo_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_full) begin
          w_load       = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        w_mdo_next = ~w_second_half;
        if (w_cell_end) w_next_state = DATA;
      end
      DATA: begin
        w_mdo_next = w_second_half ? r_rsr[7] : ~r_rsr[7];
        if (w_cell_end && (r_bitcnt == BIT_LAST)) w_next_state = GAP;
      end
      GAP: begin
        if (w_cell_end && (r_gapcnt == GAP_LAST)) begin
          if (r_full) begin
            w_load       = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) begin
      r_phase  <= 4'd0;
      r_bitcnt <= 4'd0;
      r_gapcnt <= 4'd0;
      r_thr    <= 8'h00;
      r_rsr    <= 8'h00;
      r_full   <= 1'b0;
      r_mdo    <= 1'b0;
    end else begin
      r_mdo <= w_mdo_next;

      if (r_state == IDLE) r_phase <= 4'd0;
      else                 r_phase <= r_phase + 4'd1;

      if (w_write) begin
        r_thr  <= din;
        r_full <= 1'b1;
      end

      if (w_load) begin
        r_rsr  <= r_thr;
        r_full <= 1'b0;
      end else if ((r_state == DATA) && w_cell_end) begin
        r_rsr <= {r_rsr[6:0], 1'b0};
      end

      if ((r_state == DATA) && w_cell_end)
        r_bitcnt <= (r_bitcnt == BIT_LAST) ? 4'd0 : r_bitcnt + 4'd1;

      if ((r_state == GAP) && w_cell_end)
        r_gapcnt <= (r_gapcnt == GAP_LAST) ? 4'd0 : r_gapcnt + 4'd1;
    end
  end

  assign tbre = ~r_full;
  assign tsre = (r_state == IDLE);
  assign mdo  = r_mdo;

endmodule

// File: tb/tb_manchester_encoder.sv
// tb/tb_manchester_encoder.sv - scoreboard bench for manchester_encoder
module tb_manchester_encoder;

  logic       clk16x;
  logic       rst, rst5;
  logic [7:0] din, din5;
  logic       wrn, wrn5;
  logic       tbre, tsre, mdo;
  logic       tbre5, tsre5, mdo5;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit abort_frame = 1'b0;

  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         rise5_q[$];
  int         lr5_q[$];

  manchester_encoder #(.GAP_CELLS(2)) dut (
    .clk16x(clk16x), .rst(rst), .din(din), .wrn(wrn),
    .tbre(tbre), .tsre(tsre), .mdo(mdo)
  );

  manchester_encoder #(.GAP_CELLS(5)) dut5 (
    .clk16x(clk16x), .rst(rst5), .din(din5), .wrn(wrn5),
    .tbre(tbre5), .tsre(tsre5), .mdo(mdo5)
  );

  initial clk16x = 1'b0;
  always #5 clk16x = ~clk16x;
  always @(posedge clk16x) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference waveform: one sample per clock, start cell then MSB-first data.
  function automatic logic [143:0] frame_pat(input logic [7:0] b);
    logic [143:0] p;
    logic         v;
    p = '0;
    for (int j = 0; j < 144; j++) begin
      v = (j < 16) ? 1'b0 : b[8 - (j / 16)];
      p[143 - j] = ((j % 16) < 8) ? ~v : v;
    end
    return p;
  endfunction

  task automatic do_write(input bit to5, input logic [7:0] d);
    @(negedge clk16x);
    if (to5) begin din5 = d; wrn5 = 1'b0; end
    else     begin din  = d; wrn  = 1'b0; end
    @(negedge clk16x);
    wrn  = 1'b1;
    wrn5 = 1'b1;
  endtask

  // which: 0 tsre, 1 tbre, 2 tsre5, 3 tbre5; returns cycle where it reads 1
  task automatic wait_hi(input int which, input int budget, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk16x);
      case (which)
        0:       s = tsre;
        1:       s = tbre;
        2:       s = tsre5;
        default: s = tbre5;
      endcase
      if (s === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("wait_timeout", which, -1);
  endtask

  initial begin : monitor
    logic         prev;
    logic [143:0] act, expp;
    logic [7:0]   dec, eb;
    prev = 1'b0;
    forever begin
      @(negedge clk16x);
      if (mdo === 1'b1 && prev === 1'b0) begin
        rise_q.push_back(cyc);
        act = '0;
        act[143] = 1'b1;
        for (int j = 1; j < 144; j++) begin
          @(negedge clk16x);
          act[143 - j] = mdo;
        end
        for (int k = 0; k < 8; k++) dec[7 - k] = act[143 - (16 * (k + 1) + 12)];
        if (abort_frame) begin
          abort_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %02h, expected none", dec);
        end else begin
          eb   = exp_q.pop_front();
          expp = frame_pat(eb);
          chk("decoded_byte", dec, eb);
          n_checks++;
          if (act !== expp) begin
            n_fail++;
            $display("FAIL frame_waveform: got %h, expected %h", act, expp);
          end
        end
      end
      prev = mdo;
    end
  end

  initial begin : monitor5
    int   low_run;
    logic p5;
    low_run = 0;
    p5 = 1'b0;
    forever begin
      @(negedge clk16x);
      if (mdo5 === 1'b1) begin
        if (p5 === 1'b0 && low_run >= 17) begin
          rise5_q.push_back(cyc);
          lr5_q.push_back(low_run);
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      p5 = mdo5;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   w, t, at, hi;
    logic [7:0] lb[5];
    lb[0] = 8'h3C; lb[1] = 8'h00; lb[2] = 8'hFF; lb[3] = 8'h80; lb[4] = 8'h01;

    rst = 1'b1; rst5 = 1'b1;
    din = 8'h00; din5 = 8'h00;
    wrn = 1'b1; wrn5 = 1'b1;
    repeat (3) @(negedge clk16x);
    rst = 1'b0; rst5 = 1'b0;
    @(negedge clk16x);
    chk("reset_mdo", mdo, 0);
    chk("reset_tbre", tbre, 1);
    chk("reset_tsre", tsre, 1);

    // single 0xA5 with exact write/transfer/start latencies
    exp_q.push_back(8'hA5);
    do_write(0, 8'hA5);
    w = cyc;
    t = w + 1;
    chk("a5_tbre_after_write", tbre, 0);
    chk("a5_tsre_after_write", tsre, 1);
    @(negedge clk16x);
    chk("a5_tbre_after_xfer", tbre, 1);
    chk("a5_tsre_after_xfer", tsre, 0);
    chk("a5_mdo_before_start", mdo, 0);
    @(negedge clk16x);
    chk("a5_mdo_start_rise", mdo, 1);
    wait_hi(0, 400, at);
    chk("a5_tsre_return_delay", at - t, 176);

    // loopback-style decode of several bytes
    foreach (lb[i]) begin
      exp_q.push_back(lb[i]);
      do_write(0, lb[i]);
      wait_hi(0, 400, at);
    end

    // back-to-back frames
    repeat (4) @(negedge clk16x);
    rise_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    do_write(0, 8'h55);
    t = cyc + 1;
    wait_hi(1, 10, at);
    do_write(0, 8'hAA);
    chk("b2b_tbre_held", tbre, 0);
    wait_hi(1, 400, at);
    chk("b2b_second_xfer", at - t, 176);
    wait_hi(0, 400, at);
    if (rise_q.size() >= 2) chk("b2b_start_spacing", rise_q[1] - rise_q[0], 176);
    else                    chk("b2b_start_count", rise_q.size(), 2);

    // overrun: write during transfer cycle and while holding full are dropped
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    @(negedge clk16x);
    din = 8'h11; wrn = 1'b0;
    @(negedge clk16x);
    chk("ovr_tbre_full", tbre, 0);
    din = 8'h22;
    @(negedge clk16x);
    wrn = 1'b1;
    chk("ovr_tbre_after_xfer", tbre, 1);
    do_write(0, 8'h33);
    chk("ovr_tbre_33_held", tbre, 0);
    repeat (10) @(negedge clk16x);
    do_write(0, 8'h44);
    chk("ovr_tbre_44_ignored", tbre, 0);
    wait_hi(0, 800, at);

    // reset 70 clocks into a frame with a second byte held
    do_write(0, 8'h81);
    t = cyc + 1;
    @(negedge clk16x);
    do_write(0, 8'h7E);
    chk("rst_byte_held", tbre, 0);
    while (cyc < t + 70) @(negedge clk16x);
    chk("rst_mdo_high_before", mdo, 1);
    abort_frame = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mdo_async_low", mdo, 0);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    repeat (3) @(negedge clk16x);
    rst = 1'b0;
    hi = 0;
    repeat (100) begin
      @(negedge clk16x);
      if (mdo !== 1'b0) hi++;
    end
    chk("rst_no_frame_after", hi, 0);
    chk("rst_idle_tsre", tsre, 1);
    exp_q.push_back(8'hC3);
    do_write(0, 8'hC3);
    wait_hi(0, 400, at);

    // GAP_CELLS=5 instance: gap length between back-to-back frames
    do_write(1, 8'hFF);
    wait_hi(3, 10, at);
    do_write(1, 8'h00);
    wait_hi(3, 400, at);
    wait_hi(2, 600, at);
    if (rise5_q.size() >= 2) begin
      chk("gap5_low_clocks", lr5_q[1], 80);
      chk("gap5_start_spacing", rise5_q[1] - rise5_q[0], 224);
    end else begin
      chk("gap5_start_count", rise5_q.size(), 2);
    end

    repeat (20) @(negedge clk16x);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/manchester_encoder.md
# manchester_encoder

Serial Manchester transmitter, the transmit-side counterpart of the `md` decoder on the same link. Accepts 8-bit bytes from a parallel host port through a double-buffered holding/shift register pair. Serialises each byte MSB-first as one start cell plus 8 data cells at 16 `clk16x` cycles per cell, with a mandatory low idle gap after each frame. Line format matches `md` exactly, so `md` can decode the output in loopback.

## Interface
- `GAP_CELLS`, default 2: idle-low cells forced after each frame; legal range 2..15.
- `clk16x` in 1: sole clock, 16x the bit rate.
- `rst` in 1: reset, asynchronous, active-high.
- `din` in 8: byte to transmit; sampled on the write cycle.
- `wrn` in 1: active-low write strobe, sampled synchronously on `clk16x`; each low cycle is one write attempt.
- `tbre` out 1: transmit buffer register empty; high when the holding register can accept a byte.
- `tsre` out 1: transmit shift register empty; high when no frame or gap is in progress.
- `mdo` out 1: Manchester serial output, registered; idles low.

## Operation
- Line coding, per cell of 16 clocks:
  - first half = ~b, second half = b.
  - So 1 = low→high and 0 = high→low.
- Frame:
  - start cell encoding 0 (high 8 clocks, then low 8 clocks). The rising edge from idle-low marks the cell boundary `md` aligns to.
  - then `rsr[7]`..`rsr[0]` of the shift register, MSB first.
  - then GAP_CELLS×16 clocks of `mdo`=0.
- FSM states: IDLE, START, DATA, GAP.
  - IDLE: holding register full → move it to the shift register, set holding empty, go to START.
  - START: 16 clocks → DATA.
  - DATA: 8 cells; the shift register shifts left at each cell end; after cell 8 → GAP.
  - GAP: GAP_CELLS×16 clocks. At the end, holding full → START directly (reload); otherwise → IDLE.
- Counters and widths:
  - `phase[3:0]` counts 0..15 within a cell and wraps.
  - `bitcnt[3:0]` counts 0..7 data cells.
  - `gapcnt[3:0]` counts gap cells.
  - `mdo` is ~b for phase 0..7 and b for phase 8..15.
- Write handling:
  - `wrn`=0 and `tbre`=1 → latch `din`; `tbre`=0 on the next cycle.
  - `wrn`=0 and `tbre`=0 → write ignored; holding register unchanged; no error flag.
  - A write in the same cycle as a holding→shift transfer sees the pre-transfer `tbre`=0 and is ignored.
- `tsre` is 0 from the START entry through the last GAP clock, and 1 otherwise.
- Reset values: `mdo`=0, `tbre`=1, `tsre`=1, FSM=IDLE, all counters 0, both registers 0x00. Reset mid-frame aborts the frame immediately (`mdo` low asynchronously) and discards any held byte.

## Timing
- Write sampled at edge W:
  - `tbre`=0 after W.
  - In IDLE, the transfer happens at W+1: `tbre`=1 and `tsre`=0 after W+1.
  - `mdo` rises after W+2; the start cell occupies clocks W+2..W+17.
- Frame length: 9×16 = 144 clocks of signalling, plus GAP_CELLS×16 low.
- Back-to-back writes: the next start cell begins on the clock after the last gap clock. No extra idle cycle.
- `mdo` changes only at phase 0 and phase 8 boundaries; registered, no glitches.
- Throughput at GAP_CELLS=2: one byte per 176 clocks.

## Structure
- Shared package `manchester_pkg`:
  - `CELL_CLKS`=16, `HALF_CELL`=8, `FRAME_BITS`=8.
  - FSM state enum `mtx_state_t` {IDLE, START, DATA, GAP}.
  - `md` uses the same constants.
- Single flat module. No sub-module is warranted; the cell-phase counter is inline.

## Test plan
- Reset, write 0xA5 once:
  - `mdo` rises 2 clocks after the write.
  - Start cell H/L, then half-cell sequence L H, H L, L H, H L, H L, L H, H L, L H.
  - Then 32 clocks low; `tsre` returns to 1 exactly 176 clocks after the transfer.
- Loopback into `md` (`rdn`=1): write 0x3C → `md` `dout`=0x3C and `data_ready`=1 after the frame.
  - Repeat for 0x00, 0xFF, 0x80, 0x01.
- Back-to-back: write 0x55, then 0xAA while `tbre`=1 during the first frame.
  - Second start edge exactly 176 clocks after the first.
  - `tbre` stays 0 until the second transfer.
- Overrun: write 0x11, then 0x22 while holding is full (`tbre`=0), then 0x33 after `tbre`=1.
  - 0x22 is never transmitted; 0x11 then 0x33 are sent.
- Reset asserted at clock 70 of a frame:
  - `mdo`=0 within the same cycle; `tbre`=`tsre`=1.
  - A subsequent write of 0xC3 transmits correctly.
- GAP_CELLS=5: after a 0xFF frame, measure exactly 80 low clocks before the next start edge.
